eth_link_ctrl: RTL and testbench

ETH_LINK_CTRL -- requirements
Module: eth_link_ctrl

---
 rtl/eth_link_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_eth_link_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_link_ctrl.sv
// eth_link_ctrl: GT reset sequencing plus per-lane block-lock qualification and RX datapath recovery.
// Define ETH_LINK_CTRL_RELOCK_CNT_EN to build the per-lane relock counters; otherwise relock_count reads 0.
module eth_link_ctrl #(
    parameter int LANES           = 1,
    parameter int STARTUP_CYCLES  = 1024,
    parameter int DONE_TIMEOUT    = 65536,
    parameter int DEBOUNCE_CYCLES = 64,
    parameter int LOCK_TIMEOUT    = 131072,
    parameter int DP_RESET_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gt_powergood,
    input  logic [LANES-1:0]    gt_tx_done,
    input  logic [LANES-1:0]    gt_rx_done,
    input  logic [LANES-1:0]    rx_block_lock,
    output logic                gt_reset_all,
    output logic [LANES-1:0]    gt_rx_dp_reset,
    output logic [LANES-1:0]    link_up,
    output logic [1:0]          ctrl_state,
    output logic [7:0]          retry_count,
    output logic [16*LANES-1:0] relock_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, STARTUP = 2'd1, WAIT_DONE = 2'd2, RUN = 2'd3} g_state_e;
    typedef enum logic [1:0] {LOCKING = 2'd0, UP = 2'd1, DP_RESET = 2'd2} l_state_e;
    localparam int GW = $clog2(STARTUP_CYCLES > DONE_TIMEOUT ? STARTUP_CYCLES : DONE_TIMEOUT);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT > DP_RESET_CYCLES ? LOCK_TIMEOUT : DP_RESET_CYCLES);

    g_state_e       state_q, state_d;
    logic [GW-1:0]  timer_q, timer_d;
    logic [7:0]     retry_q, retry_d;
    logic           gt_reset_all_q, gt_reset_all_d;
    logic           all_done, retry, run;
    l_state_e       lane_q [LANES], lane_d [LANES];
    logic [DW-1:0]  deb_q [LANES], deb_d [LANES];
    logic [LW-1:0]  tmr_q [LANES], tmr_d [LANES];
    logic [LANES-1:0] link_up_q, link_up_d, dp_reset_q, dp_reset_d;

    assign all_done = &{gt_tx_done, gt_rx_done};

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = STARTUP;
                timer_d = GW'(STARTUP_CYCLES - 1);
            end
            STARTUP: begin
                state_d = (timer_q == '0) ? WAIT_DONE : STARTUP;
                timer_d = (timer_q == '0) ? GW'(DONE_TIMEOUT - 1) : timer_q - GW'(1);
            end
            WAIT_DONE: begin
                state_d = all_done ? RUN : WAIT_DONE;
                retry   = !all_done && timer_q == '0;
                timer_d = timer_q - GW'(1);
            end
            RUN: retry = !all_done;
        endcase
        if (retry) begin
            state_d = STARTUP;
            timer_d = GW'(STARTUP_CYCLES - 1);
        end
        if (!gt_powergood) begin
            state_d = IDLE;
            timer_d = '0;
            retry   = 1'b0;
        end
        retry_d        = (retry && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
        gt_reset_all_d = state_d == IDLE || state_d == STARTUP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            retry_q        <= '0;
            gt_reset_all_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
            gt_reset_all_q <= gt_reset_all_d;
        end
    end

    // Lanes only advance on cycles that both start and stay in RUN, so leaving RUN clears them on the same edge.
    assign run = state_q == RUN && state_d == RUN;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_d[i] = lane_q[i];
            deb_d[i]  = deb_q[i];
            tmr_d[i]  = tmr_q[i];
            case (lane_q[i])
                LOCKING: begin
                    deb_d[i] = rx_block_lock[i] ? deb_q[i] + DW'(1) : '0;
                    tmr_d[i] = tmr_q[i] + LW'(1);
                    if (rx_block_lock[i] && deb_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        lane_d[i] = UP;
                        deb_d[i]  = '0;
                        tmr_d[i]  = '0;
                    end else if (tmr_q[i] == LW'(LOCK_TIMEOUT - 1)) begin
                        lane_d[i] = DP_RESET;
                        tmr_d[i]  = '0;
                    end
                end
                UP: begin
                    deb_d[i] = rx_block_lock[i] ? '0 : deb_q[i] + DW'(1);
                    if (!rx_block_lock[i] && deb_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        lane_d[i] = DP_RESET;
                        deb_d[i]  = '0;
                        tmr_d[i]  = '0;
                    end
                end
                default: begin
                    tmr_d[i] = tmr_q[i] + LW'(1);
                    if (tmr_q[i] == LW'(DP_RESET_CYCLES - 1)) begin
                        lane_d[i] = LOCKING;
                        deb_d[i]  = '0;
                        tmr_d[i]  = '0;
                    end
                end
            endcase
            if (!run) begin
                lane_d[i] = LOCKING;
                deb_d[i]  = '0;
                tmr_d[i]  = '0;
            end
            link_up_d[i]  = lane_d[i] == UP;
            dp_reset_d[i] = lane_d[i] == DP_RESET;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (rst) begin
                lane_q[i] <= LOCKING;
                deb_q[i]  <= '0;
                tmr_q[i]  <= '0;
            end else begin
                lane_q[i] <= lane_d[i];
                deb_q[i]  <= deb_d[i];
                tmr_q[i]  <= tmr_d[i];
            end
        end
        if (rst) begin
            link_up_q  <= '0;
            dp_reset_q <= '0;
        end else begin
            link_up_q  <= link_up_d;
            dp_reset_q <= dp_reset_d;
        end
    end

`ifdef ETH_LINK_CTRL_RELOCK_CNT_EN
    logic [15:0] relock_q [LANES], relock_d [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++)
            relock_d[i] = (lane_q[i] != DP_RESET && lane_d[i] == DP_RESET && relock_q[i] != 16'hFFFF) ?
                          relock_q[i] + 16'd1 : relock_q[i];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            relock_q[i] <= rst ? 16'd0 : relock_d[i];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_relock
        assign relock_count[16*g +: 16] = relock_q[g];
    end
`else
    assign relock_count = '0;
`endif

    assign gt_reset_all   = gt_reset_all_q;
    assign gt_rx_dp_reset = dp_reset_q;
    assign link_up        = link_up_q;
    assign ctrl_state     = state_q;
    assign retry_count    = retry_q;
endmodule

// File: tb/tb_eth_link_ctrl.sv
// tb_eth_link_ctrl: directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_eth_link_ctrl;
    localparam int SC = 16, DT = 64, DEB = 4, LTO = 32, DPR = 8;
`ifdef ETH_LINK_CTRL_RELOCK_CNT_EN
    localparam int RC = 1;
`else
    localparam int RC = 0;
`endif

    logic        clk = 1'b0, rst = 1'b1, gt_powergood = 1'b0;
    logic [1:0]  gt_tx_done = '0, gt_rx_done = '0, rx_block_lock = '0;
    logic        gt_reset_all;
    logic [1:0]  gt_rx_dp_reset, link_up, ctrl_state;
    logic [7:0]  retry_count;
    logic [31:0] relock_count;

    int checks = 0, errors = 0;
    int m_phase = 0, m_elapsed = 0, m_retry = 0;
    int l_mode [2] = '{0, 0}, l_streak [2] = '{0, 0}, l_age [2] = '{0, 0}, l_relock [2] = '{0, 0};

    always #5 clk = ~clk;

    eth_link_ctrl #(
        .LANES(2), .STARTUP_CYCLES(SC), .DONE_TIMEOUT(DT),
        .DEBOUNCE_CYCLES(DEB), .LOCK_TIMEOUT(LTO), .DP_RESET_CYCLES(DPR)
    ) dut (
        .clk(clk), .rst(rst), .gt_powergood(gt_powergood),
        .gt_tx_done(gt_tx_done), .gt_rx_done(gt_rx_done), .rx_block_lock(rx_block_lock),
        .gt_reset_all(gt_reset_all), .gt_rx_dp_reset(gt_rx_dp_reset), .link_up(link_up),
        .ctrl_state(ctrl_state), .retry_count(retry_count), .relock_count(relock_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic lane_enter(input int i, input int mode);
        l_mode[i]   = mode;
        l_streak[i] = 0;
        l_age[i]    = 0;
    endtask

    task automatic relock_bump(input int i);
        if (l_relock[i] < 65535) l_relock[i]++;
    endtask

    task automatic model_step();
        int np;
        bit done, rt;
        done = &{gt_tx_done, gt_rx_done};
        rt = 0;
        if (rst) begin
            m_phase = 0; m_elapsed = 0; m_retry = 0;
            for (int i = 0; i < 2; i++) begin
                lane_enter(i, 0);
                l_relock[i] = 0;
            end
            return;
        end
        np = m_phase;
        if (!gt_powergood) np = 0;
        else if (m_phase == 0) np = 1;
        else if (m_phase == 1) np = (m_elapsed == SC - 1) ? 2 : 1;
        else if (m_phase == 2) begin
            if (done) np = 3;
            else if (m_elapsed == DT - 1) begin np = 1; rt = 1; end
        end else if (!done) begin np = 1; rt = 1; end
        for (int i = 0; i < 2; i++) begin
            if (!(m_phase == 3 && np == 3)) lane_enter(i, 0);
            else if (l_mode[i] == 0) begin
                l_age[i]++;
                l_streak[i] = rx_block_lock[i] ? l_streak[i] + 1 : 0;
                if (l_streak[i] == DEB) lane_enter(i, 1);
                else if (l_age[i] == LTO) begin lane_enter(i, 2); relock_bump(i); end
            end else if (l_mode[i] == 1) begin
                l_streak[i] = rx_block_lock[i] ? 0 : l_streak[i] + 1;
                if (l_streak[i] == DEB) begin lane_enter(i, 2); relock_bump(i); end
            end else begin
                l_age[i]++;
                if (l_age[i] == DPR) lane_enter(i, 0);
            end
        end
        if (rt && m_retry < 255) m_retry++;
        m_elapsed = (np == m_phase) ? m_elapsed + 1 : 0;
        m_phase = np;
    endtask

    task automatic check_outputs();
        logic [1:0] lu, dp;
        for (int i = 0; i < 2; i++) begin
            lu[i] = l_mode[i] == 1;
            dp[i] = l_mode[i] == 2;
        end
        chk("ctrl_state", 32'(ctrl_state), 32'(m_phase));
        chk("gt_reset_all", 32'(gt_reset_all), 32'(m_phase < 2));
        chk("link_up", 32'(link_up), 32'(lu));
        chk("gt_rx_dp_reset", 32'(gt_rx_dp_reset), 32'(dp));
        chk("retry_count", 32'(retry_count), 32'(m_retry));
        chk("relock_count", relock_count, {16'(l_relock[1] * RC), 16'(l_relock[0] * RC)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int n, rises;
        logic prev;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        gt_powergood  = 1'b1;
        rx_block_lock = 2'b11;
        n = 0;
        while (m_phase != 2 && n < 100) begin tick(); n++; end
        repeat (10) tick();
        gt_tx_done = 2'b11;
        gt_rx_done = 2'b11;
        n = 0;
        while (ctrl_state != 2'd3 && n < 20) begin tick(); n++; end
        chk("run_entry", 32'(ctrl_state), 32'd3);
        repeat (3) tick();
        chk("link_early", 32'(link_up), 32'd0);
        tick();
        chk("link_after_deb", 32'(link_up), 32'd3);
        chk("retry_bringup", 32'(retry_count), 32'd0);

        rx_block_lock[0] = 1'b0;
        repeat (3) tick();
        rx_block_lock[0] = 1'b1;
        repeat (2) tick();
        chk("glitch3_link", 32'(link_up), 32'd3);
        rx_block_lock[0] = 1'b0;
        repeat (4) tick();
        chk("loss4_link", 32'(link_up), 32'd2);
        rx_block_lock[0] = 1'b1;
        n = 0;
        while (gt_rx_dp_reset[0] && n < 50) begin n++; tick(); end
        chk("dp_len0", 32'(n), 32'(DPR));
        chk("relock_lane0", relock_count, 32'(RC));
        repeat (6) tick();
        chk("relink0", 32'(link_up), 32'd3);

        rx_block_lock[1] = 1'b0;
        rises = 0;
        prev = gt_rx_dp_reset[1];
        repeat (200) begin
            tick();
            if (gt_rx_dp_reset[1] && !prev) rises++;
            prev = gt_rx_dp_reset[1];
        end
        chk("lock_to_pulses", 32'(rises), 32'd5);
        chk("relock_lane1", relock_count, {16'(5 * RC), 16'(RC)});
        rx_block_lock[1] = 1'b1;
        repeat (50) tick();
        chk("pre_pg_link", 32'(link_up), 32'd3);
        gt_powergood = 1'b0;
        tick();
        chk("pg_drop_state", 32'(ctrl_state), 32'd0);
        chk("pg_drop_link", 32'(link_up), 32'd0);
        chk("pg_drop_rst", 32'(gt_reset_all), 32'd1);
        gt_powergood = 1'b1;

        for (int t = 0; t < 3000; t++) begin
            gt_powergood = $urandom_range(0, 399) != 0;
            rst = $urandom_range(0, 1499) == 0;
            if ($urandom_range(0, 99) == 0) begin
                gt_tx_done = 2'($urandom);
                gt_rx_done = 2'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                gt_tx_done = 2'b11;
                gt_rx_done = 2'b11;
            end
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 7) == 0) rx_block_lock[i] = ~rx_block_lock[i];
            tick();
        end

        rst = 1'b0;
        gt_powergood = 1'b1;
        gt_tx_done = 2'b11;
        gt_rx_done = 2'b11;
        rx_block_lock = 2'b11;
        repeat (150) tick();
        chk("pre_timeout_run", 32'(ctrl_state), 32'd3);
        gt_rx_done[1] = 1'b0;
        tick();
        n = 0;
        while (gt_reset_all && n < 100) begin n++; tick(); end
        chk("startup_len", 32'(n), 32'(SC));
        n = 0;
        while (ctrl_state == 2'd2 && n < 200) begin n++; tick(); end
        chk("wait_done_len", 32'(n), 32'(DT));
        repeat (300 * (SC + DT)) tick();
        chk("retry_saturate", 32'(retry_count), 32'd255);

        n = 0;
        while (ctrl_state != 2'd2 && n < 100) begin tick(); n++; end
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("rst_state", 32'(ctrl_state), 32'd0);
        chk("rst_reset_all", 32'(gt_reset_all), 32'd1);
        chk("rst_retry", 32'(retry_count), 32'd0);
        chk("rst_relock", relock_count, 32'd0);
        chk("rst_link", 32'(link_up), 32'd0);
        chk("rst_dp", 32'(gt_rx_dp_reset), 32'd0);
        rst = 1'b0;
        gt_rx_done = 2'b11;
        repeat (60) tick();
        chk("final_link", 32'(link_up), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
